// File: rtl/baby_pkg.sv
// Shared constants and types for the Baby main-store datapath blocks.
package baby_pkg;

   localparam int unsigned LINE_LENGTH         = 40;
   localparam int unsigned ADDR_BITS           = 5;
   localparam int unsigned INSTR_FUNCTION_BITS = 6;
   localparam int unsigned DIGIT_BITS          = 6;

   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_JMP = 6'b000000;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_JRP = 6'b001000;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_SUB = 6'b000010;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_CMP = 6'b011000;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_STA = 6'b010100;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_LDA = 6'b100000;
   localparam logic [INSTR_FUNCTION_BITS-1:0] INST_STP = 6'b111000;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      WRITE,
      DONE
   } state_e;

   typedef enum logic {
      MODE_STORE,
      MODE_CLEAR
   } mode_e;

endpackage

// File: rtl/digit_counter.sv
// Digit index counter for a line scan; saturates at the last digit of the line.
module digit_counter #(
   parameter int unsigned Width = 6,
   parameter int unsigned Last  = 39
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o,
   output logic             last_o
);

   logic [Width-1:0] count_q, count_d;

   assign last_o = (count_q == Width'(Last));

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !last_o) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/inward_transfer_gate.sv
// Serially writes the accumulator (or zeros for a manual line clear) into one
// main-store line, one registered write per digit strobe.
module inward_transfer_gate #(
   parameter int unsigned LINE_LENGTH         = baby_pkg::LINE_LENGTH,
   parameter int unsigned ADDR_BITS           = baby_pkg::ADDR_BITS,
   parameter int unsigned INSTR_FUNCTION_BITS = baby_pkg::INSTR_FUNCTION_BITS,
   parameter logic [INSTR_FUNCTION_BITS-1:0] INST_STA = baby_pkg::INST_STA,
   parameter int unsigned DIGIT_BITS          = baby_pkg::DIGIT_BITS
) (
   input  logic                           w_CLK,
   input  logic                           w_RST_N,
   input  logic                           w_REQ,
   input  logic                           w_PARA_ACTION,
   input  logic [INSTR_FUNCTION_BITS-1:0] b_FST,
   input  logic                           w_KLC,
   input  logic                           w_HA,
   input  logic [ADDR_BITS-1:0]           b_LST_out,
   input  logic                           w_BEAT_START,
   input  logic                           w_DIGIT,
   input  logic                           w_A_DATA_OUT,
   output logic [ADDR_BITS-1:0]           b_MS_ADDR,
   output logic [DIGIT_BITS-1:0]          b_MS_DIGIT,
   output logic                           w_MS_DATA_IN,
   output logic                           w_MS_WE,
   output logic                           w_BUSY,
   output logic                           w_DONE
);

   import baby_pkg::*;

   state_e                  state_q, state_d;
   mode_e                   mode_q, mode_d;
   logic [ADDR_BITS-1:0]    addr_q, addr_d;
   logic [DIGIT_BITS-1:0]   digit_q, digit_d;
   logic                    we_q, we_d;
   logic                    data_q, data_d;

   logic                    cnt_clr;
   logic                    strobe;
   logic [DIGIT_BITS-1:0]   cnt;
   logic                    cnt_last;

   digit_counter #(
      .Width (DIGIT_BITS),
      .Last  (LINE_LENGTH - 1)
   ) u_digit_counter (
      .clk_i   (w_CLK),
      .rst_ni  (w_RST_N),
      .clr_i   (cnt_clr),
      .inc_i   (strobe),
      .count_o (cnt),
      .last_o  (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      cnt_clr = 1'b0;
      strobe  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (w_REQ && ((w_KLC && w_HA) || (w_PARA_ACTION && (b_FST == INST_STA)))) begin
               state_d = ARMED;
               mode_d  = (w_KLC && w_HA) ? MODE_CLEAR : MODE_STORE;
               addr_d  = b_LST_out;
               cnt_clr = 1'b1;
            end
         end
         ARMED: begin
            // A strobe coinciding with the beat start is digit 0.
            if (w_BEAT_START) begin
               state_d = WRITE;
               strobe  = w_DIGIT;
            end
         end
         WRITE: begin
            strobe = w_DIGIT;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (strobe && cnt_last) begin
         state_d = DONE;
      end

      we_d    = strobe;
      data_d  = strobe && (mode_q == MODE_STORE) && w_A_DATA_OUT;
      digit_d = strobe ? cnt : digit_q;
   end

   always_ff @(posedge w_CLK or negedge w_RST_N) begin
      if (!w_RST_N) begin
         state_q <= IDLE;
         mode_q  <= MODE_STORE;
         addr_q  <= '0;
         digit_q <= '0;
         we_q    <= 1'b0;
         data_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         digit_q <= digit_d;
         we_q    <= we_d;
         data_q  <= data_d;
      end
   end

   assign b_MS_ADDR    = addr_q;
   assign b_MS_DIGIT   = digit_q;
   assign w_MS_DATA_IN = data_q;
   assign w_MS_WE      = we_q;
   assign w_BUSY       = (state_q != IDLE);
   assign w_DONE       = (state_q == DONE);

endmodule

// File: tb/tb_inward_transfer_gate.sv
// Randomised bench for inward_transfer_gate against a transaction-level store-line model.
module tb_inward_transfer_gate;

   localparam int LL = 40;
   localparam logic [5:0] STA = 6'b010100;
   localparam logic [5:0] LDA = 6'b100000;

   logic       clk, rst_n, req, pa, klc, ha, beat, dig, a;
   logic [5:0] fst;
   logic [4:0] lst;
   logic [4:0] ms_addr;
   logic [5:0] ms_digit;
   logic       ms_data, ms_we, busy, done;

   int errors = 0;
   int checks = 0;

   inward_transfer_gate dut (
      .w_CLK         (clk),
      .w_RST_N       (rst_n),
      .w_REQ         (req),
      .w_PARA_ACTION (pa),
      .b_FST         (fst),
      .w_KLC         (klc),
      .w_HA          (ha),
      .b_LST_out     (lst),
      .w_BEAT_START  (beat),
      .w_DIGIT       (dig),
      .w_A_DATA_OUT  (a),
      .b_MS_ADDR     (ms_addr),
      .b_MS_DIGIT    (ms_digit),
      .w_MS_DATA_IN  (ms_data),
      .w_MS_WE       (ms_we),
      .w_BUSY        (busy),
      .w_DONE        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at t=%0t", name, got, want, $time);
      end
   endtask

   // Transaction-level model: a transfer is active, has a line position and
   // produces the expected write one clock after each accepted strobe.
   bit         m_active, m_started, m_clear, m_done, m_we, m_data, s;
   int         m_next, m_digit;
   logic [4:0] m_addr;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_started = 0; m_clear = 0; m_done = 0;
         m_we = 0; m_data = 0; m_next = 0; m_digit = 0; m_addr = '0;
      end else begin
         m_we = 0; m_data = 0; s = 0;
         if (m_done) begin
            m_done = 0;
            m_active = 0;
         end else if (!m_active) begin
            if (req && ((klc && ha) || (pa && fst == STA))) begin
               m_active = 1; m_started = 0; m_clear = klc && ha;
               m_addr = lst; m_next = 0;
            end
         end else begin
            if (!m_started && beat) begin
               m_started = 1;
               s = dig;
            end else if (m_started) begin
               s = dig;
            end
            if (s) begin
               m_we = 1;
               m_data = m_clear ? 1'b0 : a;
               m_digit = m_next;
               m_next++;
               if (m_next == LL) m_done = 1;
            end
         end
      end
   end

   // Observed store contents and event counts, for the literal checks.
   logic [LL-1:0] mem [32];
   int wr_cnt = 0;
   int done_cnt = 0;
   int done_digit = -1;
   bit done_we = 0;

   initial forever begin
      @(posedge clk);
      #1;
      chk("we", ms_we, m_we);
      chk("data", ms_data, m_data);
      chk("digit", ms_digit, m_digit[5:0]);
      chk("addr", ms_addr, m_addr);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (ms_we) begin
         wr_cnt++;
         mem[ms_addr][ms_digit] = ms_data;
      end
      if (done) begin
         done_cnt++;
         done_digit = int'(ms_digit);
         done_we = ms_we;
      end
   end

   task automatic cyc(input bit r, input bit b, input bit d, input bit av);
      @(negedge clk);
      req = r; beat = b; dig = d; a = av;
   endtask

   task automatic send_req(input bit p, input logic [5:0] f, input bit k, input bit h,
                           input logic [4:0] l);
      @(negedge clk);
      req = 1; pa = p; fst = f; klc = k; ha = h; lst = l; beat = 0; dig = 0;
      // Post-acceptance changes on the qualifiers must not matter.
      @(negedge clk);
      req = 0; pa = 1'($urandom); fst = 6'($urandom); klc = 1'($urandom);
      ha = 1'($urandom); lst = 5'($urandom);
   endtask

   task automatic zero_outputs(input string tag);
      chk({tag, ".we"}, ms_we, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".addr"}, ms_addr, 0);
      chk({tag, ".digit"}, ms_digit, 0);
      chk({tag, ".data"}, ms_data, 0);
   endtask

   task automatic run_line(input logic [LL-1:0] word, input bit beat_dig, input int junk,
                           input int coll_at, input int spur_at, input int rst_at);
      int i;
      repeat (junk) cyc(0, 0, 1, 1'($urandom));
      if (beat_dig) begin
         cyc(0, 1, 1, word[0]);
         i = 1;
      end else begin
         cyc(0, 1, 0, 1'($urandom));
         i = 0;
      end
      for (; i < LL; i++) begin
         repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 1'($urandom));
         if (i == coll_at) begin
            lst = 5'd3; klc = 1; ha = 1; pa = 1; fst = STA;
         end
         cyc(i == coll_at, i == spur_at, 1, word[i]);
         if (i == rst_at) begin
            #2 rst_n = 0;
            #1 zero_outputs("async_rst");
            @(negedge clk);
            @(negedge clk);
            req = 0; beat = 0; dig = 0;
            rst_n = 1;
            return;
         end
      end
      repeat (3) cyc(0, 0, 0, 1'($urandom));
   endtask

   int w0, d0;
   logic [LL-1:0] word;
   logic [63:0] rnd;

   initial begin
      rst_n = 0; req = 0; pa = 0; fst = '0; klc = 0; ha = 0; lst = '0;
      beat = 0; dig = 0; a = 0;
      for (int i = 0; i < 32; i++) mem[i] = '1;
      #1 zero_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1;

      // STA store to line 7
      w0 = wr_cnt; d0 = done_cnt;
      send_req(1, STA, 0, 0, 5'd7);
      run_line(40'hA5_0F_00_FF_3C, 1, 0, -1, -1, -1);
      chk("sta.writes", wr_cnt - w0, 40);
      chk("sta.dones", done_cnt - d0, 1);
      chk("sta.word", mem[7], 40'hA5_0F_00_FF_3C);
      chk("sta.addr", ms_addr, 7);
      chk("sta.done_digit", done_digit, 39);
      chk("sta.done_we", done_we, 1);

      // Manual clear of line 31 with an all-ones accumulator
      w0 = wr_cnt; d0 = done_cnt;
      send_req(0, LDA, 1, 1, 5'd31);
      run_line('1, 0, 2, -1, -1, -1);
      chk("clr.writes", wr_cnt - w0, 40);
      chk("clr.word", mem[31], 40'h0);

      // Rejected LDA request
      w0 = wr_cnt; d0 = done_cnt;
      send_req(1, LDA, 0, 0, 5'd9);
      chk("rej.busy", busy, 0);
      run_line('1, 1, 0, -1, -1, -1);
      chk("rej.writes", wr_cnt - w0, 0);
      chk("rej.dones", done_cnt - d0, 0);

      // Busy collisions: second request at digit 10, stray beat at digit 20
      w0 = wr_cnt; d0 = done_cnt;
      send_req(1, STA, 0, 0, 5'd12);
      run_line(40'h12_3456_789A, 1, 0, 10, 20, -1);
      chk("coll.writes", wr_cnt - w0, 40);
      chk("coll.dones", done_cnt - d0, 1);
      chk("coll.addr", ms_addr, 12);
      chk("coll.word", mem[12], 40'h12_3456_789A);

      // Reset at digit 25, then a clean transfer
      w0 = wr_cnt; d0 = done_cnt;
      send_req(1, STA, 0, 0, 5'd20);
      run_line(40'hFF_FFFF_FFFF, 1, 0, -1, -1, 25);
      chk("rst.writes", wr_cnt - w0, 25);
      chk("rst.dones", done_cnt - d0, 0);
      w0 = wr_cnt; d0 = done_cnt;
      send_req(1, STA, 0, 0, 5'd21);
      run_line(40'hC3_0000_5A5A, 0, 1, -1, -1, -1);
      chk("post_rst.writes", wr_cnt - w0, 40);
      chk("post_rst.dones", done_cnt - d0, 1);
      chk("post_rst.word", mem[21], 40'hC3_0000_5A5A);

      // Random transfers: store, clear, both, or rejected
      for (int k = 0; k < 14; k++) begin
         int kind;
         rnd = {$urandom, $urandom};
         word = rnd[LL-1:0];
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: send_req(1, STA, 0, 1'($urandom), 5'($urandom));
            1: send_req(1'($urandom), 6'($urandom), 1, 1, 5'($urandom));
            2: send_req(1, STA, 1, 1, 5'($urandom));
            default: send_req(1'($urandom), LDA, 1'($urandom), 0, 5'($urandom));
         endcase
         run_line(word, 1'($urandom), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 39)) : -1,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 39)) : -1, -1);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
